multicycle_ctrl_fsm: RTL and testbench

Control unit for the multicycle RV32I datapath variant; consumes the instruction fields latched in the instruction register.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects, write enables and the ALU operation. ALU codes use alu_op_t; opcodes use inst_t.
- Sits between the instruction register/memory interface and the datapath (ALU, register file, PC).

---
 rtl/multicycle_ctrl_fsm_if.sv | 87 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//
// Connects the multicycle RV32I control unit to the instruction register, the
// memory interface and the datapath. The signal names carry the control
// unit's point of view (_i into the controller, _o out of it).
//
// Signals:
//   op_i, funct3_i, funct7b5_i  instruction fields from the instruction register
//   zero_i                      ALU zero flag
//   mem_ready_i                 memory access completes this cycle
//   pc_write_o, ir_write_o      PC / instruction register enables
//   adr_src_o                   memory address select (0=PC, 1=ALU result)
//   mem_write_o                 memory write strobe
//   result_src_o                00=ALUOut, 01=read data, 10=ALU result
//   alu_src_a_o                 00=PC, 01=oldPC, 10=rs1
//   alu_src_b_o                 00=rs2, 01=imm, 10=const 4
//   imm_src_o                   00=I, 01=S, 10=B, 11=J
//   reg_write_o                 register file write enable
//   alu_control_o               ALU operation (ADD/SUB/AND/OR/SLT)
//   instr_done_o                pulse in the last state of each instruction
//   illegal_o                   sticky illegal-opcode flag
//
// Modports:
//   master  the control unit
//   slave   the datapath / instruction register / memory side
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic       pc_write_o;
    logic       adr_src_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic [1:0] result_src_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] imm_src_o;
    logic       reg_write_o;
    logic [2:0] alu_control_o;
    logic       instr_done_o;
    logic       illegal_o;

    modport master (
        input  op_i,
        input  funct3_i,
        input  funct7b5_i,
        input  zero_i,
        input  mem_ready_i,
        output pc_write_o,
        output adr_src_o,
        output mem_write_o,
        output ir_write_o,
        output result_src_o,
        output alu_src_a_o,
        output alu_src_b_o,
        output imm_src_o,
        output reg_write_o,
        output alu_control_o,
        output instr_done_o,
        output illegal_o
    );

    modport slave (
        output op_i,
        output funct3_i,
        output funct7b5_i,
        output zero_i,
        output mem_ready_i,
        input  pc_write_o,
        input  adr_src_o,
        input  mem_write_o,
        input  ir_write_o,
        input  result_src_o,
        input  alu_src_a_o,
        input  alu_src_b_o,
        input  imm_src_o,
        input  reg_write_o,
        input  alu_control_o,
        input  instr_done_o,
        input  illegal_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control unit for the multicycle RV32I datapath. Each instruction is walked
// through FETCH, DECODE and the execute / memory / writeback states its
// opcode needs; the state drives the datapath mux selects, write enables and
// the ALU operation.
//
// Ports:
//   clk    core clock, all state on the rising edge
//   rst_n  synchronous active-low reset (state -> FETCH, illegal flag cleared;
//          write enables and instr_done are held low while it is asserted)
//   bus    multicycle_ctrl_fsm_if.master: instruction fields, zero flag and
//          memory ready in; control word, instr_done and illegal flag out
//
// Parameter:
//   RESET_STATE_FETCH  must be 1; FETCH is the only legal reset state.
//
// Optional feature (macro ILLEGAL_TRAP_EN):
//   defined   - an unknown opcode in DECODE parks the FSM in TRAP (left only
//               by reset) and raises the sticky illegal_o from the next cycle
//   undefined - an unknown opcode retires as a NOP from DECODE; illegal_o = 0
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master bus
);

    typedef enum logic [6:0] {
        OP_LW     = 7'b0000011,
        OP_I_TYPE = 7'b0010011,
        OP_SW     = 7'b0100011,
        OP_R_TYPE = 7'b0110011,
        OP_B_TYPE = 7'b1100011,
        OP_J_TYPE = 7'b1101111
    } inst_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd11
`endif
    } state_t;

    // The reset state is fixed; any other selector value is a configuration error.
    generate
        if (RESET_STATE_FETCH != 1) begin : g_bad_reset_sel
            $error("multicycle_ctrl_fsm: RESET_STATE_FETCH must be 1");
        end
    endgenerate

    // funct3 000 is SUB only for register-register ops (op[5]=1) with instr[30]
    // set; the immediate form never subtracts.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic       funct7b5,
                                           input logic       op5);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t     state_q;
    state_t     state_d;

    logic       pc_write_c;
    logic       ir_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       done_c;
    logic       adr_src_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] imm_src_c;
    alu_op_t    alu_c;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and control word
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        done_c       = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_c        = ALU_ADD;

        case (state_q)
            FETCH: begin
                // PC + 4 goes straight back to the PC through the result mux.
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (bus.mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end

            DECODE: begin
                // oldPC + imm: the branch target lands in ALUOut for BEQ.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.op_i)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R_TYPE:    state_d = EXECUTER;
                    OP_I_TYPE:    state_d = EXECUTEI;
                    OP_J_TYPE:    state_d = JAL;
                    OP_B_TYPE:    state_d = BEQ;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        done_c  = 1'b1;
                        state_d = FETCH;
`endif
                    end
                endcase
            end

            MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (bus.op_i == OP_SW) ? MEMWRITE : MEMREAD;
            end

            MEMREAD: begin
                adr_src_c = 1'b1;
                if (bus.mem_ready_i) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                state_d      = FETCH;
            end

            MEMWRITE: begin
                // The strobe stays up until memory accepts; done marks that cycle.
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready_i) begin
                    done_c  = 1'b1;
                    state_d = FETCH;
                end
            end

            EXECUTER: begin
                alu_src_a_c = 2'b10;
                alu_c       = alu_decode(bus.funct3_i, bus.funct7b5_i, bus.op_i[5]);
                state_d     = ALUWB;
            end

            EXECUTEI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_c       = alu_decode(bus.funct3_i, bus.funct7b5_i, bus.op_i[5]);
                state_d     = ALUWB;
            end

            ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = FETCH;
            end

            JAL: begin
                // PC takes the jump target held in ALUOut while the ALU forms
                // oldPC + 4 for the link register written in ALUWB.
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = ALUWB;
            end

            BEQ: begin
                // rs1 - rs2 sets zero; the target computed in DECODE sits in ALUOut.
                alu_src_a_c = 2'b10;
                alu_c       = ALU_SUB;
                pc_write_c  = bus.zero_i;
                done_c      = 1'b1;
                state_d     = FETCH;
            end

`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                state_d = TRAP;
            end
`endif

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Immediate format, decoded straight from the opcode
    // ---------------------------------------------------------------------
    always_comb begin
        case (bus.op_i)
            OP_SW:     imm_src_c = 2'b01;
            OP_B_TYPE: imm_src_c = 2'b10;
            OP_J_TYPE: imm_src_c = 2'b11;
            default:   imm_src_c = 2'b00;
        endcase
    end

    // ---------------------------------------------------------------------
    // Illegal-opcode flag
    // ---------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == DECODE && state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal_o = illegal_q;
`else
    assign bus.illegal_o = 1'b0;
`endif

    // Enables are gated by rst_n so a reset landing mid-instruction can never
    // commit a write in the reset cycle itself.
    assign bus.pc_write_o    = pc_write_c  & rst_n;
    assign bus.ir_write_o    = ir_write_c  & rst_n;
    assign bus.mem_write_o   = mem_write_c & rst_n;
    assign bus.reg_write_o   = reg_write_c & rst_n;
    assign bus.instr_done_o  = done_c      & rst_n;
    assign bus.adr_src_o     = adr_src_c;
    assign bus.result_src_o  = result_src_c;
    assign bus.alu_src_a_o   = alu_src_a_c;
    assign bus.alu_src_b_o   = alu_src_b_c;
    assign bus.imm_src_o     = imm_src_c;
    assign bus.alu_control_o = alu_c;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Self-checking bench for multicycle_ctrl_fsm. Directed scenarios compare the
// full control word cycle by cycle against hand-written values; the random
// scenario runs a stream of instructions with random memory stalls against a
// behavioural model that expands each instruction class into its list of
// steps and derives the control word of each step. Inputs change 1 time unit
// after the rising edge and outputs are sampled 4 units later.
// Control-word layout used for comparisons (MSB first):
//   pc_write adr_src mem_write ir_write result_src[2] a[2] b[2] imm_src[2]
//   reg_write alu[3] instr_done illegal
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EXR, P_EXI, P_WB, P_JAL, P_BEQ} ph_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.RESET_STATE_FETCH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] pack(input logic pcw, input logic adr, input logic mw,
                                         input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] imm, input logic rw,
                                         input logic [2:0] alu, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, done, ill};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.pc_write_o, bus.adr_src_o, bus.mem_write_o, bus.ir_write_o,
                bus.result_src_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.imm_src_o,
                bus.reg_write_o, bus.alu_control_o, bus.instr_done_o, bus.illegal_o};
    endfunction

    // Behavioural model: control word expected for one step of an instruction.
    function automatic logic [17:0] model_out(input ph_t ph, input logic [6:0] op,
                                              input logic [2:0] f3, input logic f7,
                                              input logic z, input logic rdy);
        logic [1:0] imm;
        logic [2:0] alu;
        logic       known;
        imm = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : (op == OP_J) ? 2'b11 : 2'b00;
        if (f3 == 3'b000)      alu = (f7 && op[5]) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) alu = 3'b101;
        else if (f3 == 3'b110) alu = 3'b011;
        else if (f3 == 3'b111) alu = 3'b010;
        else                   alu = 3'b000;
        known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
                (op == OP_B) || (op == OP_J);
        case (ph)
            P_F:   return pack(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, imm, 1'b0, 3'b000, 1'b0, 1'b0);
            P_D:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 3'b000, !known, 1'b0);
            P_MA:  return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, 3'b000, 1'b0, 1'b0);
            P_MR:  return pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 3'b000, 1'b0, 1'b0);
            P_MWB: return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, imm, 1'b1, 3'b000, 1'b1, 1'b0);
            P_MW:  return pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 3'b000, rdy, 1'b0);
            P_EXR: return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, alu, 1'b0, 1'b0);
            P_EXI: return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 1'b0, alu, 1'b0, 1'b0);
            P_WB:  return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 1'b1, 3'b000, 1'b1, 1'b0);
            P_JAL: return pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 1'b0, 3'b000, 1'b0, 1'b0);
            default: return pack(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 1'b0, 3'b001, 1'b1, 1'b0);
        endcase
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic rdy);
        bus.op_i        = op;
        bus.funct3_i    = f3;
        bus.funct7b5_i  = f7;
        bus.zero_i      = z;
        bus.mem_ready_i = rdy;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] ex[9];
        logic        rs[9];
        logic        rd[9];
        logic [17:0] o;
        rst_n = 1'b0;
        set_in(OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        // two cycles in reset, then SW up to MEMWRITE, reset there for 2 cycles
        rs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rd = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ex[0] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[2] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[3] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[4] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[5] = pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[6] = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[7] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[8] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            rst_n = rs[i];
            set_in(OP_SW, 3'b010, 1'b0, 1'b0, rd[i]);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL reset_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_rtype();
        logic [17:0] ex[5];
        logic [17:0] o;
        ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[2] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0);
        ex[3] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0);
        ex[4] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_in(OP_R, 3'b000, 1'b1, 1'b0, (i < 4) ? 1'b1 : 1'b0);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL rtype_sub_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [17:0] ex[8];
        logic        rd[8];
        logic [17:0] o;
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[2] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 3; i < 7; i++)
            ex[i] = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[7] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_in(OP_LW, 3'b010, 1'b0, 1'b0, rd[i]);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL lw_stall_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [17:0] ex[3];
        logic [17:0] o;
        for (int zz = 1; zz >= 0; zz--) begin
            ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0);
            ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0);
            ex[2] = pack(zz[0], 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b001, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                set_in(OP_B, 3'b000, 1'b0, zz[0], 1'b1);
                o = obs();
                n_cmp++;
                if (o !== ex[i]) begin
                    n_bad++;
                    $display("FAIL beq_z%0d_c%0d: got %b want %b", zz, i, o, ex[i]);
                end
                tick();
            end
        end
    endtask

    task automatic test_jal();
        logic [17:0] ex[4];
        logic [17:0] o;
        ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[2] = pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[3] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(OP_J, 3'b000, 1'b0, 1'b0, 1'b1);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL jal_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
    endtask

`ifdef ILLEGAL_TRAP_EN
    task automatic test_illegal();
        logic [17:0] ex[7];
        logic        rs[7];
        logic [17:0] o;
        logic [17:0] trap_w;
        trap_w = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
        rs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[2] = trap_w;
        ex[3] = trap_w;
        ex[4] = trap_w;
        ex[5] = trap_w;
        ex[6] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            rst_n = rs[i];
            set_in(OP_BAD, 3'b000, 1'b0, 1'b1, (i < 6) ? 1'b1 : 1'b0);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL illegal_trap_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask
`else
    task automatic test_illegal();
        logic [17:0] ex[3];
        logic [17:0] o;
        ex[0] = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        ex[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 1'b1, 1'b0);
        ex[2] = pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_in(OP_BAD, 3'b000, 1'b0, 1'b0, (i < 2) ? 1'b1 : 1'b0);
            o = obs();
            n_cmp++;
            if (o !== ex[i]) begin
                n_bad++;
                $display("FAIL illegal_nop_c%0d: got %b want %b", i, o, ex[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        ph_t         q[$];
        int          cls;
        int          cyc;
        int          stalls;
        int          done_at;
        int          lat_exp;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [17:0] e;
        logic [17:0] o;
        logic [6:0]  bad_ops[3];
        bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111};
        for (int n = 0; n < 120; n++) begin
`ifdef ILLEGAL_TRAP_EN
            cls = $urandom_range(0, 5);
`else
            cls = $urandom_range(0, 6);
`endif
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            case (cls)
                0:       begin op = OP_R;  q = {P_F, P_D, P_EXR, P_WB};       lat_exp = 4; end
                1:       begin op = OP_I;  q = {P_F, P_D, P_EXI, P_WB};       lat_exp = 4; end
                2:       begin op = OP_LW; q = {P_F, P_D, P_MA, P_MR, P_MWB}; lat_exp = 5; end
                3:       begin op = OP_SW; q = {P_F, P_D, P_MA, P_MW};        lat_exp = 4; end
                4:       begin op = OP_B;  q = {P_F, P_D, P_BEQ};             lat_exp = 3; end
                5:       begin op = OP_J;  q = {P_F, P_D, P_JAL, P_WB};       lat_exp = 4; end
                default: begin op = bad_ops[$urandom_range(0, 2)]; q = {P_F, P_D}; lat_exp = 2; end
            endcase
            cyc     = 0;
            stalls  = 0;
            done_at = 0;
            while (q.size() > 0 && cyc < 40) begin
                rdy = ($urandom_range(0, 3) != 0);
                z   = 1'($urandom);
                set_in(op, f3, f7, z, rdy);
                e = model_out(q[0], op, f3, f7, z, rdy);
                o = obs();
                cyc++;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL rand_word n=%0d op=%b cyc=%0d: got %b want %b", n, op, cyc, o, e);
                end
                if (o[1] === 1'b1 && done_at == 0) done_at = cyc;
                if ((q[0] == P_F || q[0] == P_MR || q[0] == P_MW) && !rdy) stalls++;
                else void'(q.pop_front());
                tick();
            end
            n_cmp++;
            if (done_at != lat_exp + stalls) begin
                n_bad++;
                $display("FAIL rand_latency n=%0d op=%b: got %0d want %0d", n, op, done_at, lat_exp + stalls);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.op_i        = OP_R;
        bus.funct3_i    = 3'b000;
        bus.funct7b5_i  = 1'b0;
        bus.zero_i      = 1'b0;
        bus.mem_ready_i = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_jal();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
